// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle MIPS-subset controller: opcode and
// func encodings, ALU control codes, datapath mux selects, state codes, the
// control-word struct and the per-state control decode.
package multicycle_controller_pkg;

   // Instruction opcodes (instruction[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // R-type func codes (instruction[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   // ALU operation codes
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALU B-operand select
   localparam logic [1:0] SRC_B_REG    = 2'b00;
   localparam logic [1:0] SRC_B_FOUR   = 2'b01;
   localparam logic [1:0] SRC_B_IMM    = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

   // PC source select
   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] PC_SRC_REG_A  = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_I_EXEC    = 4'd8,
      S_I_WB      = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11,
      S_JAL       = 4'd12,
      S_JR        = 4'd13
   } state_t;

   typedef struct packed {
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic       jal_reg;
      logic       pc_to_reg;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_cntrl;
      logic       pc_write;
      logic       pc_write_cond;
      logic       instr_done;
   } ctrl_t;

   // Moore control word for a state. r_alu is the func-derived ALU code used
   // in R_EXEC; opcode selects add vs slt in I_EXEC. Unlisted fields stay 0,
   // and unused state codes yield an all-zero word.
   function automatic ctrl_t ctrl_for_state(input state_t s, input logic [2:0] r_alu,
                                            input logic [5:0] opcode);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.ir_write  = 1'b1;
            c.alu_src_b = SRC_B_FOUR;
            c.alu_cntrl = ALU_ADD;
            c.pc_write  = 1'b1;
            c.pc_source = PC_SRC_ALU;
         end
         S_DECODE: begin
            c.alu_src_b = SRC_B_IMM_SH;
            c.alu_cntrl = ALU_ADD;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_cntrl = ALU_ADD;
         end
         S_MEM_READ: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_MEM_WRITE: begin
            c.mem_write  = 1'b1;
            c.i_or_d     = 1'b1;
            c.instr_done = 1'b1;
         end
         S_R_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRC_B_REG;
            c.alu_cntrl = r_alu;
         end
         S_R_WB: begin
            c.reg_dst    = 1'b1;
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_I_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_cntrl = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
         end
         S_I_WB: begin
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRC_B_REG;
            c.alu_cntrl     = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PC_SRC_ALUOUT;
            c.instr_done    = 1'b1;
         end
         S_JUMP: begin
            c.pc_write   = 1'b1;
            c.pc_source  = PC_SRC_JUMP;
            c.instr_done = 1'b1;
         end
         S_JAL: begin
            c.pc_write   = 1'b1;
            c.pc_source  = PC_SRC_JUMP;
            c.instr_done = 1'b1;
            c.reg_write  = 1'b1;
            c.jal_reg    = 1'b1;
            c.pc_to_reg  = 1'b1;
         end
         S_JR: begin
            c.pc_write   = 1'b1;
            c.pc_source  = PC_SRC_REG_A;
            c.instr_done = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_control.sv
// alu_control: decodes the R-type func field into an ALU operation code.
// Ports:
//   func      in  6  instruction[5:0]
//   alu_cntrl out 3  ALU operation (0 when func is unsupported)
//   func_ok   out 1  func is a supported R-type arithmetic/logic op
module alu_control
   import multicycle_controller_pkg::*;
(
   input  logic [5:0] func,
   output logic [2:0] alu_cntrl,
   output logic       func_ok
);

   always_comb begin
      alu_cntrl = ALU_AND;
      func_ok   = 1'b1;
      case (func)
         FN_ADD:  alu_cntrl = ALU_ADD;
         FN_SUB:  alu_cntrl = ALU_SUB;
         FN_AND:  alu_cntrl = ALU_AND;
         FN_OR:   alu_cntrl = ALU_OR;
         FN_SLT:  alu_cntrl = ALU_SLT;
         default: func_ok   = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle MIPS-subset
// datapath (lw, sw, add/sub/and/or/slt, addi, slti, beq, j, jal, jr).
// Ports:
//   clk, rst (sync, active-high)
//   opcode, func      instruction fields from the instruction register
//   ZERO              ALU zero flag
//   pc_load           PC write enable = pc_write | (pc_write_cond & ZERO)
//   i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
//   alu_src_a, jal_reg, pc_to_reg, alu_src_b, pc_source, alu_cntrl
//                     datapath controls
//   instr_done        pulse in the last state of each instruction
//   illegal_op        sticky unsupported opcode/func flag
//   state             current state code (debug)
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   input  logic       ZERO,
   output logic       pc_load,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic       jal_reg,
   output logic       pc_to_reg,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [2:0] alu_cntrl,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_t     state_q;
   state_t     next_state;
   logic       set_illegal;
   ctrl_t      ctrl_q;
   logic [2:0] r_alu;
   logic       func_ok;

   alu_control u_alu_control (
      .func      (func),
      .alu_cntrl (r_alu),
      .func_ok   (func_ok)
   );

   // NOTE: every variable driven here gets a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state  = S_FETCH;
      set_illegal = 1'b0;
      case (state_q)
         S_FETCH:    next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:     next_state = S_MEM_ADDR;
               OP_RTYPE:         next_state = (func == FN_JR) ? S_JR : S_R_EXEC;
               OP_ADDI, OP_SLTI: next_state = S_I_EXEC;
               OP_BEQ:           next_state = S_BRANCH;
               OP_J:             next_state = S_JUMP;
               OP_JAL:           next_state = S_JAL;
               default:          set_illegal = 1'b1;
            endcase
         end
         S_MEM_ADDR: next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ: next_state = S_MEM_WB;
         S_R_EXEC: begin
            // Unsupported func aborts without reaching the write-back state.
            if (func_ok) next_state = S_R_WB;
            else         set_illegal = 1'b1;
         end
         S_I_EXEC:   next_state = S_I_WB;
         default:    next_state = S_FETCH;
      endcase
   end

   // The control word is registered alongside the state, computed from the
   // state being entered, so outputs are glitch-free Moore outputs.
   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from values sampled at the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         illegal_op <= 1'b0;
         ctrl_q     <= ctrl_for_state(S_FETCH, r_alu, opcode);
      end else begin
         state_q <= next_state;
         ctrl_q  <= ctrl_for_state(next_state, r_alu, opcode);
         if (set_illegal) illegal_op <= 1'b1;
      end
   end

   // Architectural writes are suppressed for as long as reset is held,
   // including when reset lands in the middle of an instruction.
   assign pc_load    = ~rst & (ctrl_q.pc_write | (ctrl_q.pc_write_cond & ZERO));
   assign mem_write  = ~rst & ctrl_q.mem_write;
   assign reg_write  = ~rst & ctrl_q.reg_write;
   assign ir_write   = ~rst & ctrl_q.ir_write;

   assign i_or_d     = ctrl_q.i_or_d;
   assign mem_read   = ctrl_q.mem_read;
   assign reg_dst    = ctrl_q.reg_dst;
   assign mem_to_reg = ctrl_q.mem_to_reg;
   assign alu_src_a  = ctrl_q.alu_src_a;
   assign jal_reg    = ctrl_q.jal_reg;
   assign pc_to_reg  = ctrl_q.pc_to_reg;
   assign alu_src_b  = ctrl_q.alu_src_b;
   assign pc_source  = ctrl_q.pc_source;
   assign alu_cntrl  = ctrl_q.alu_cntrl;
   assign instr_done = ctrl_q.instr_done;
   assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a table of instructions with
// expected state sequences and per-state expected outputs, plus hand-written
// sequences for reset, illegal opcode/func and same-cycle ZERO behaviour.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, func;
   logic       zero;
   logic       pc_load, i_or_d, mem_read, mem_write, ir_write, reg_dst;
   logic       mem_to_reg, reg_write, alu_src_a, jal_reg, pc_to_reg;
   logic [1:0] alu_src_b, pc_source;
   logic [2:0] alu_cntrl;
   logic       instr_done, illegal_op;
   logic [3:0] state;

   multicycle_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func(func), .ZERO(zero),
      .pc_load(pc_load), .i_or_d(i_or_d), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .jal_reg(jal_reg), .pc_to_reg(pc_to_reg), .alu_src_b(alu_src_b),
      .pc_source(pc_source), .alu_cntrl(alu_cntrl), .instr_done(instr_done),
      .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_load, ir_write, mem_read, mem_write, reg_write, i_or_d;
      logic       reg_dst, mem_to_reg, alu_src_a, jal_reg, pc_to_reg, instr_done;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_cntrl;
   } outs_t;

   typedef struct {
      string      name;
      logic [5:0] opcode;
      logic [5:0] func;
      logic       zero;
      int         n;
      int         st[5];
      logic [2:0] alu;   // expected ALU code in R_EXEC / I_EXEC
   } vec_t;

   outs_t base[14];
   vec_t  vecs[15];
   int    n_checks = 0;
   int    n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic outs_t sample();
      outs_t s;
      s.pc_load = pc_load;     s.ir_write = ir_write;     s.mem_read = mem_read;
      s.mem_write = mem_write; s.reg_write = reg_write;   s.i_or_d = i_or_d;
      s.reg_dst = reg_dst;     s.mem_to_reg = mem_to_reg; s.alu_src_a = alu_src_a;
      s.jal_reg = jal_reg;     s.pc_to_reg = pc_to_reg;   s.instr_done = instr_done;
      s.alu_src_b = alu_src_b; s.pc_source = pc_source;   s.alu_cntrl = alu_cntrl;
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Precondition: 1 time unit after a rising edge, DUT in FETCH.
   task automatic run_vec(input vec_t v, input logic exp_ill);
      outs_t e;
      opcode = v.opcode; func = v.func; zero = v.zero;
      for (int c = 0; c < v.n; c++) begin
         @(negedge clk);
         e = base[v.st[c]];
         if (v.st[c] == 10) e.pc_load = v.zero;
         if (v.st[c] == 6 || v.st[c] == 8) e.alu_cntrl = v.alu;
         check($sformatf("%s c%0d state", v.name, c), 32'(state), 32'(v.st[c]));
         check($sformatf("%s c%0d outs", v.name, c), 32'(sample()), 32'(e));
         check($sformatf("%s c%0d illegal", v.name, c), 32'(illegal_op), 32'(exp_ill));
         step();
      end
   endtask

   // Run op for k cycles to land in target, then assert reset inside it.
   task automatic reset_in(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input int k, input int target, input logic [3:0] pre_wr);
      opcode = op; func = fn; zero = 1'b1;
      repeat (k) step();
      @(negedge clk);
      check({nm, " pre state"}, 32'(state), 32'(target));
      check({nm, " pre writes"}, 32'({pc_load, ir_write, mem_write, reg_write}), 32'(pre_wr));
      rst = 1'b1;
      #1;
      check({nm, " rst writes"}, 32'({pc_load, ir_write, mem_write, reg_write}), 32'(0));
      step();
      check({nm, " rst state"}, 32'(state), 32'(0));
      @(negedge clk);
      check({nm, " held writes"}, 32'({pc_load, ir_write, mem_write, reg_write}), 32'(0));
      step();
      rst = 1'b0;
      #1;
      check({nm, " post state"}, 32'(state), 32'(0));
      check({nm, " post fetch writes"}, 32'({pc_load, ir_write}), 32'(2'b11));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Expected outputs per state; unlisted outputs are 0.
      for (int i = 0; i < 14; i++) base[i] = '0;
      base[0].pc_load = 1; base[0].ir_write = 1; base[0].mem_read = 1;
      base[0].alu_src_b = 2'b01; base[0].alu_cntrl = 3'b010;
      base[1].alu_src_b = 2'b11; base[1].alu_cntrl = 3'b010;
      base[2].alu_src_a = 1; base[2].alu_src_b = 2'b10; base[2].alu_cntrl = 3'b010;
      base[3].mem_read = 1; base[3].i_or_d = 1;
      base[4].mem_to_reg = 1; base[4].reg_write = 1; base[4].instr_done = 1;
      base[5].mem_write = 1; base[5].i_or_d = 1; base[5].instr_done = 1;
      base[6].alu_src_a = 1; base[6].alu_src_b = 2'b00;
      base[7].reg_dst = 1; base[7].reg_write = 1; base[7].instr_done = 1;
      base[8].alu_src_a = 1; base[8].alu_src_b = 2'b10;
      base[9].reg_write = 1; base[9].instr_done = 1;
      base[10].alu_src_a = 1; base[10].alu_cntrl = 3'b110;
      base[10].pc_source = 2'b01; base[10].instr_done = 1;
      base[11].pc_load = 1; base[11].pc_source = 2'b10; base[11].instr_done = 1;
      base[12].pc_load = 1; base[12].pc_source = 2'b10; base[12].instr_done = 1;
      base[12].reg_write = 1; base[12].jal_reg = 1; base[12].pc_to_reg = 1;
      base[13].pc_load = 1; base[13].pc_source = 2'b11; base[13].instr_done = 1;

      vecs[0]  = '{"lw",     6'b100011, 6'b000000, 1'b0, 5, '{0, 1, 2, 3, 4},  3'b000};
      vecs[1]  = '{"sw",     6'b101011, 6'b000000, 1'b0, 4, '{0, 1, 2, 5, 0},  3'b000};
      vecs[2]  = '{"add",    6'b000000, 6'b100000, 1'b0, 4, '{0, 1, 6, 7, 0},  3'b010};
      vecs[3]  = '{"sub",    6'b000000, 6'b100010, 1'b0, 4, '{0, 1, 6, 7, 0},  3'b110};
      vecs[4]  = '{"and",    6'b000000, 6'b100100, 1'b0, 4, '{0, 1, 6, 7, 0},  3'b000};
      vecs[5]  = '{"or",     6'b000000, 6'b100101, 1'b0, 4, '{0, 1, 6, 7, 0},  3'b001};
      vecs[6]  = '{"slt",    6'b000000, 6'b101010, 1'b0, 4, '{0, 1, 6, 7, 0},  3'b111};
      vecs[7]  = '{"addi",   6'b001000, 6'b000111, 1'b0, 4, '{0, 1, 8, 9, 0},  3'b010};
      vecs[8]  = '{"slti",   6'b001010, 6'b000000, 1'b0, 4, '{0, 1, 8, 9, 0},  3'b111};
      vecs[9]  = '{"beq_z1", 6'b000100, 6'b000000, 1'b1, 3, '{0, 1, 10, 0, 0}, 3'b000};
      vecs[10] = '{"beq_z0", 6'b000100, 6'b000000, 1'b0, 3, '{0, 1, 10, 0, 0}, 3'b000};
      vecs[11] = '{"j",      6'b000010, 6'b000000, 1'b0, 3, '{0, 1, 11, 0, 0}, 3'b000};
      vecs[12] = '{"jal",    6'b000011, 6'b000000, 1'b0, 3, '{0, 1, 12, 0, 0}, 3'b000};
      vecs[13] = '{"jr",     6'b000000, 6'b001000, 1'b0, 3, '{0, 1, 13, 0, 0}, 3'b000};
      vecs[14] = '{"lw2",    6'b100011, 6'b101010, 1'b1, 5, '{0, 1, 2, 3, 4},  3'b000};

      // Reset held two cycles, writes suppressed throughout.
      rst = 1'b1; opcode = 6'b000100; func = 6'b0; zero = 1'b1;
      step();
      @(negedge clk);
      check("reset writes", 32'({pc_load, ir_write, mem_write, reg_write}), 32'(0));
      step();
      rst = 1'b0;
      #1;
      check("reset state", 32'(state), 32'(0));
      check("reset illegal", 32'(illegal_op), 32'(0));
      check("first fetch pc_load/ir_write", 32'({pc_load, ir_write}), 32'(2'b11));

      for (int v = 0; v < 15; v++) run_vec(vecs[v], 1'b0);

      // pc_load follows ZERO within the BRANCH cycle, no clock needed.
      opcode = 6'b000100; zero = 1'b0;
      step(); step();
      check("beq state", 32'(state), 32'(10));
      check("beq zero0 pc_load", 32'(pc_load), 32'(0));
      zero = 1'b1;
      #1;
      check("beq zero1 pc_load", 32'(pc_load), 32'(1));
      zero = 1'b0;
      #1;
      check("beq zero back pc_load", 32'(pc_load), 32'(0));
      step();
      check("beq return", 32'(state), 32'(0));

      // Reset landing mid-instruction.
      reset_in("rst_in_lw", 6'b100011, 6'b0, 3, 3, 4'b0000);
      reset_in("rst_in_jal", 6'b000011, 6'b0, 2, 12, 4'b1001);
      reset_in("rst_in_sw", 6'b101011, 6'b0, 3, 5, 4'b0010);
      run_vec(vecs[2], 1'b0);

      // Illegal opcode: DECODE -> FETCH, flag sticky afterwards.
      opcode = 6'b111111; func = 6'b100000;
      @(negedge clk);
      check("ill_op fetch state", 32'(state), 32'(0));
      step();
      @(negedge clk);
      check("ill_op decode state", 32'(state), 32'(1));
      check("ill_op decode flag", 32'(illegal_op), 32'(0));
      step();
      check("ill_op back to fetch", 32'(state), 32'(0));
      check("ill_op flag set", 32'(illegal_op), 32'(1));
      run_vec(vecs[3], 1'b1);
      run_vec(vecs[12], 1'b1);
      reset_in("rst_clears_ill", 6'b000010, 6'b0, 2, 11, 4'b1000);
      check("ill cleared by reset", 32'(illegal_op), 32'(0));

      // Illegal func: R_EXEC aborts to FETCH without a write.
      opcode = 6'b000000; func = 6'b000111;
      step(); step();
      @(negedge clk);
      check("ill_fn exec state", 32'(state), 32'(6));
      check("ill_fn exec no write", 32'({reg_write, instr_done}), 32'(0));
      check("ill_fn exec flag", 32'(illegal_op), 32'(0));
      step();
      check("ill_fn back to fetch", 32'(state), 32'(0));
      check("ill_fn flag set", 32'(illegal_op), 32'(1));
      check("ill_fn no write", 32'(reg_write), 32'(0));
      run_vec(vecs[0], 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
